// File: rtl/bcd_room_counter.sv
// Multi-digit BCD up/down room tally with a synchronised, edge-detected step input.
// Also provides parallel load, wrap/saturate boundary modes and one-cycle status pulses.
module bcd_room_counter #(
  parameter int          DIGITS   = 2,
  parameter int          SEL_W    = 8,
  parameter int unsigned SEL_UP   = 5,
  parameter int unsigned SEL_DOWN = 21,
  parameter bit          WRAP     = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [SEL_W-1:0]      Selector,
  input  logic                  Increment,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadValue,
  output logic [4*DIGITS-1:0]   RoomDigits,
  output logic                  Carry,
  output logic                  Borrow,
  output logic                  AtLimit,
  output logic                  LoadError,
  output logic                  Zero
);

  localparam int W = 4 * DIGITS;

  logic         inc_s1_q, inc_s2_q, inc_prev_q;
  logic [W-1:0] digits_q, digits_d;
  logic         carry_q, carry_d, borrow_q, borrow_d;
  logic         at_limit_q, at_limit_d, load_err_q, load_err_d;
  logic         zero_q;

  logic         step;
  logic [W-1:0] inc_val, dec_val;
  logic         inc_c, dec_b;
  logic         all_nines, all_zero, load_ok;

  // Two flops resynchronise the pushbutton; the third remembers the last level.
  assign step = inc_s2_q & ~inc_prev_q;

  // Ripple the BCD carry/borrow from digit 0 upward.
  always_comb begin
    // NOTE: blocking assignments here model a combinational ripple chain;
    // every variable gets a default first so no latch can be inferred.
    inc_val   = digits_q;
    dec_val   = digits_q;
    inc_c     = 1'b1;
    dec_b     = 1'b1;
    all_nines = 1'b1;
    all_zero  = 1'b1;
    load_ok   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_c) begin
        if (digits_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
          inc_c             = 1'b0;
        end
      end
      if (dec_b) begin
        if (digits_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
          dec_b             = 1'b0;
        end
      end
      all_nines = all_nines & (digits_q[4*i +: 4] == 4'd9);
      all_zero  = all_zero  & (digits_q[4*i +: 4] == 4'd0);
      load_ok   = load_ok   & (LoadValue[4*i +: 4] <= 4'd9);
    end
  end

  always_comb begin
    digits_d   = digits_q;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    at_limit_d = 1'b0;
    load_err_d = 1'b0;
    if (Load) begin
      // A step arriving with Load is dropped, never deferred.
      if (load_ok) digits_d = LoadValue;
      else         load_err_d = 1'b1;
    end else if (step) begin
      if (Selector == SEL_W'(SEL_UP)) begin
        if (!all_nines)  digits_d = inc_val;
        else if (WRAP) begin
          digits_d = '0;
          carry_d  = 1'b1;
        end else         at_limit_d = 1'b1;
      end else if (Selector == SEL_W'(SEL_DOWN)) begin
        if (!all_zero)   digits_d = dec_val;
        else if (WRAP) begin
          digits_d = {DIGITS{4'd9}};
          borrow_d = 1'b1;
        end else         at_limit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; Reset is synchronous and overrides all.
    if (Reset) begin
      inc_s1_q   <= 1'b0;
      inc_s2_q   <= 1'b0;
      inc_prev_q <= 1'b0;
      digits_q   <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      at_limit_q <= 1'b0;
      load_err_q <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      inc_s1_q   <= Increment;
      inc_s2_q   <= inc_s1_q;
      inc_prev_q <= inc_s2_q;
      digits_q   <= digits_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      at_limit_q <= at_limit_d;
      load_err_q <= load_err_d;
      zero_q     <= (digits_d == '0);
    end
  end

  assign RoomDigits = digits_q;
  assign Carry      = carry_q;
  assign Borrow     = borrow_q;
  assign AtLimit    = at_limit_q;
  assign LoadError  = load_err_q;
  assign Zero       = zero_q;

endmodule

// File: tb/tb_bcd_room_counter.sv
// Directed bench for bcd_room_counter: wrap and saturate 2-digit instances
// share one stimulus table; a 4-digit instance covers wide carry and reset.
module tb_bcd_room_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sel;
  logic        inc;
  logic        load;
  logic [15:0] load_val;

  logic [7:0]  w_digits, s_digits;
  logic [15:0] d_digits;
  logic        w_c, w_b, w_a, w_e, w_z;
  logic        s_c, s_b, s_a, s_e, s_z;
  logic        d_c, d_b, d_a, d_e, d_z;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bcd_room_counter #(.DIGITS(2), .WRAP(1'b1)) u_wrap (
    .Clock(clk), .Reset(rst), .Selector(sel), .Increment(inc), .Load(load),
    .LoadValue(load_val[7:0]), .RoomDigits(w_digits), .Carry(w_c), .Borrow(w_b),
    .AtLimit(w_a), .LoadError(w_e), .Zero(w_z));

  bcd_room_counter #(.DIGITS(2), .WRAP(1'b0)) u_sat (
    .Clock(clk), .Reset(rst), .Selector(sel), .Increment(inc), .Load(load),
    .LoadValue(load_val[7:0]), .RoomDigits(s_digits), .Carry(s_c), .Borrow(s_b),
    .AtLimit(s_a), .LoadError(s_e), .Zero(s_z));

  bcd_room_counter #(.DIGITS(4), .WRAP(1'b1)) u_wide (
    .Clock(clk), .Reset(rst), .Selector(sel), .Increment(inc), .Load(load),
    .LoadValue(load_val), .RoomDigits(d_digits), .Carry(d_c), .Borrow(d_b),
    .AtLimit(d_a), .LoadError(d_e), .Zero(d_z));

  typedef enum logic {K_LOAD, K_STEP} kind_e;

  // Flags packed as {Carry, Borrow, AtLimit, LoadError}.
  typedef struct {
    kind_e      kind;
    logic [7:0] sel;
    logic [7:0] val;
    logic [7:0] exp_w;
    logic [3:0] flg_w;
    logic [7:0] exp_s;
    logic [3:0] flg_s;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    load     = 1'b1;
    load_val = v;
    @(posedge clk);
    #1;
  endtask

  // Increment rises before E0; the result is visible just after E2.
  task automatic do_step(input logic [7:0] s);
    @(negedge clk);
    sel = s;
    inc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    load = 1'b0;
    inc  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{K_LOAD, 8'd0,  8'h99, 8'h99, 4'b0000, 8'h99, 4'b0000};
    vecs[1]  = '{K_STEP, 8'd5,  8'h00, 8'h00, 4'b1000, 8'h99, 4'b0010};
    vecs[2]  = '{K_STEP, 8'd21, 8'h00, 8'h99, 4'b0100, 8'h98, 4'b0000};
    vecs[3]  = '{K_LOAD, 8'd0,  8'h00, 8'h00, 4'b0000, 8'h00, 4'b0000};
    vecs[4]  = '{K_STEP, 8'd21, 8'h00, 8'h99, 4'b0100, 8'h00, 4'b0010};
    vecs[5]  = '{K_LOAD, 8'd0,  8'h3A, 8'h99, 4'b0001, 8'h00, 4'b0001};
    vecs[6]  = '{K_LOAD, 8'd0,  8'hA0, 8'h99, 4'b0001, 8'h00, 4'b0001};
    vecs[7]  = '{K_LOAD, 8'd0,  8'h19, 8'h19, 4'b0000, 8'h19, 4'b0000};
    vecs[8]  = '{K_STEP, 8'd5,  8'h00, 8'h20, 4'b0000, 8'h20, 4'b0000};
    vecs[9]  = '{K_STEP, 8'd7,  8'h00, 8'h20, 4'b0000, 8'h20, 4'b0000};
    vecs[10] = '{K_STEP, 8'd21, 8'h00, 8'h19, 4'b0000, 8'h19, 4'b0000};
    vecs[11] = '{K_LOAD, 8'd0,  8'h01, 8'h01, 4'b0000, 8'h01, 4'b0000};
    vecs[12] = '{K_STEP, 8'd21, 8'h00, 8'h00, 4'b0000, 8'h00, 4'b0000};

    rst = 1'b1; sel = 8'd0; inc = 1'b0; load = 1'b0; load_val = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_digits", w_digits, 8'h00);
    check("reset_zero", w_z, 1'b1);
    check("reset_flags", {w_c, w_b, w_a, w_e}, 4'b0000);
    check("reset_wide", {d_z, d_digits}, {1'b1, 16'h0000});
    @(negedge clk);
    rst = 1'b0;

    // Twelve up-steps from reset.
    for (int i = 0; i < 12; i++) begin
      do_step(8'd5);
      settle();
    end
    check("count12_digits", w_digits, 8'h12);
    check("count12_zero", w_z, 1'b0);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].kind == K_LOAD) do_load({8'h00, vecs[i].val});
      else                        do_step(vecs[i].sel);
      check($sformatf("vec%0d_wrap_digits", i), w_digits, vecs[i].exp_w);
      check($sformatf("vec%0d_wrap_flags", i), {w_c, w_b, w_a, w_e}, vecs[i].flg_w);
      check($sformatf("vec%0d_wrap_zero", i), w_z, vecs[i].exp_w == 8'h00);
      check($sformatf("vec%0d_sat_digits", i), s_digits, vecs[i].exp_s);
      check($sformatf("vec%0d_sat_flags", i), {s_c, s_b, s_a, s_e}, vecs[i].flg_s);
      check($sformatf("vec%0d_sat_zero", i), s_z, vecs[i].exp_s == 8'h00);
      @(negedge clk);
      load = 1'b0;
      inc  = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_pulse_clear", i), {w_c, w_b, w_a, w_e, s_c, s_b, s_a, s_e}, 8'h00);
      settle();
    end

    // Held-high Increment: no change at E1, one step at E2, nothing more.
    do_load(16'h0007);
    settle();
    @(negedge clk);
    sel = 8'd5;
    inc = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("held_before_e2", w_digits, 8'h07);
    @(posedge clk);
    #1;
    check("held_at_e2", w_digits, 8'h08);
    repeat (17) @(posedge clk);
    #1;
    check("held_after_20", w_digits, 8'h08);
    settle();

    // Load coinciding with the step cycle wins and the step is lost.
    do_load(16'h0010);
    settle();
    @(negedge clk);
    sel = 8'd5;
    inc = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    load     = 1'b1;
    load_val = 16'h0045;
    @(posedge clk);
    #1;
    check("load_vs_step", w_digits, 8'h45);
    settle();
    check("step_not_deferred", w_digits, 8'h45);

    // Four-digit ripple, rejected wide load, and reset during a pending step.
    do_load(16'h0999);
    settle();
    do_step(8'd5);
    check("wide_ripple", d_digits, 16'h1000);
    check("wide_no_carry", d_c, 1'b0);
    settle();
    do_load(16'hA000);
    check("wide_load_err", {d_e, d_digits}, {1'b1, 16'h1000});
    settle();
    do_load(16'h0999);
    settle();
    @(negedge clk);
    inc = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_on_step", {d_z, d_digits}, {1'b1, 16'h0000});
    @(negedge clk);
    inc = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("step_discarded", {d_z, d_digits}, {1'b1, 16'h0000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
